axis_i2c_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI-Stream-driven I2C byte-write master between NUM_REQ requesters.
- Accepts one word (7-bit addr, R/W bit, 8-bit data) from the winning requester and forwards it to the master.
- Holds off further grants until the master reports the bus transaction done, or a timeout expires.
- Sits between the system-side AXIS producers and the I2C master's AXIS slave port.

---
 rtl/axis_i2c_arbiter.sv | 135 +++++++++++++
 tb/tb_axis_i2c_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter sharing one AXIS-fed I2C byte-write master between NUM_REQ requesters.
// One word is forwarded per grant; the next grant waits for i2c_done or a timeout.
module axis_i2c_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          arstn,
   input  logic [NUM_REQ-1:0]            s_tvalid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
   output logic [NUM_REQ-1:0]            s_tready,
   output logic                          m_tvalid,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   input  logic                          m_tready,
   input  logic                          i2c_done,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_DONE
   } state_t;

   state_t                state, state_nx;
   logic [IW-1:0]         rr_ptr, rr_nx;
   logic [IW-1:0]         grant_nx;
   logic [IW-1:0]         winner;
   logic [IW-1:0]         cand;
   logic [IW-1:0]         advance;
   logic                  found;
   logic [DATA_WIDTH-1:0] hold, hold_nx;
   logic [TW-1:0]         timer, timer_nx;
   logic                  tmo_hit;
   logic                  tmo_nx;
   int                    idx;

   // Cyclic search starting at rr_ptr; first valid requester wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = IW'(idx);
         if (!found && s_tvalid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      s_tready = '0;
      if (arstn && state == IDLE && found)
         s_tready[winner] = 1'b1;
   end

   assign advance  = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);
   assign tmo_hit  = (timer == T_LAST);
   assign m_tvalid = (state == SEND);
   assign m_tdata  = (state == SEND) ? hold : '0;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      grant_nx = grant_id;
      hold_nx  = hold;
      timer_nx = timer;
      tmo_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               hold_nx  = s_tdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
               grant_nx = winner;
               timer_nx = '0;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (!tmo_hit) timer_nx = timer + TW'(1);
            if (m_tready) begin
               state_nx = WAIT_DONE;
            end else if (tmo_hit) begin
               state_nx = IDLE;
               rr_nx    = advance;
               tmo_nx   = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tmo_hit) timer_nx = timer + TW'(1);
            // Completion beats a coincident timeout.
            if (i2c_done) begin
               state_nx = IDLE;
               rr_nx    = advance;
            end else if (tmo_hit) begin
               state_nx = IDLE;
               rr_nx    = advance;
               tmo_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         hold        <= '0;
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         rr_ptr      <= rr_nx;
         grant_id    <= grant_nx;
         hold        <= hold_nx;
         timer       <= timer_nx;
         timeout_err <= tmo_nx;
      end
   end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed bench for axis_i2c_arbiter: one default instance plus
// a TIMEOUT_CYCLES=16 instance sharing the same stimulus.
module tb_axis_i2c_arbiter;

   logic        clk;
   logic        arstn;
   logic [3:0]  s_tvalid;
   logic [63:0] s_tdata;
   logic        m_tready;
   logic        i2c_done;

   logic [3:0]  a_s_tready, t_s_tready;
   logic        a_m_tvalid, t_m_tvalid;
   logic [15:0] a_m_tdata, t_m_tdata;
   logic [1:0]  a_grant_id, t_grant_id;
   logic        a_busy, t_busy;
   logic        a_timeout_err, t_timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   axis_i2c_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(1024)
   ) u_dut (
      .clk(clk), .arstn(arstn),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(a_s_tready),
      .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata), .m_tready(m_tready),
      .i2c_done(i2c_done), .grant_id(a_grant_id),
      .busy(a_busy), .timeout_err(a_timeout_err)
   );

   axis_i2c_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(16)
   ) u_dut_t (
      .clk(clk), .arstn(arstn),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(t_s_tready),
      .m_tvalid(t_m_tvalid), .m_tdata(t_m_tdata), .m_tready(m_tready),
      .i2c_done(i2c_done), .grant_id(t_grant_id),
      .busy(t_busy), .timeout_err(t_timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered at a negedge in IDLE with s_tvalid already set.
   task automatic serve(input int id, input logic [15:0] dat,
                        input int bp, input int gap);
      logic [3:0] one;
      one = 4'b0001 << id;
      #1;
      chk("req_ready", a_s_tready, one);
      @(negedge clk);
      chk("send_valid", a_m_tvalid, 1);
      chk("send_data", a_m_tdata, dat);
      chk("grant_id", a_grant_id, id);
      m_tready = 1'b0;
      for (int k = 0; k < bp; k++) begin
         i2c_done = (k == 0);
         @(negedge clk);
         i2c_done = 1'b0;
         chk("bp_valid", a_m_tvalid, 1);
         chk("bp_data", a_m_tdata, dat);
         chk("bp_ready", a_s_tready, 0);
      end
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
      chk("wait_valid", a_m_tvalid, 0);
      chk("wait_busy", a_busy, 1);
      repeat (gap) @(negedge clk);
      chk("gap_busy", a_busy, 1);
      i2c_done = 1'b1;
      @(negedge clk);
      i2c_done = 1'b0;
      chk("idle_busy", a_busy, 0);
      chk("idle_grant", a_grant_id, id);
   endtask

   initial begin
      arstn    = 1'b0;
      s_tvalid = 4'b1111;
      s_tdata  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      m_tready = 1'b0;
      i2c_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", a_s_tready, 0);
      chk("rst_valid", a_m_tvalid, 0);
      chk("rst_data", a_m_tdata, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_tmo", a_timeout_err, 0);
      chk("rst_grant", a_grant_id, 0);
      @(negedge clk);
      arstn = 1'b1;

      // All four held valid: order 0,1,2,3,0; requester 2 sees backpressure.
      serve(0, 16'h1111, 0, 2);
      serve(1, 16'h2222, 1, 0);
      serve(2, 16'h3333, 10, 0);
      serve(3, 16'h4444, 0, 0);
      serve(0, 16'h1111, 0, 0);
      s_tvalid = 4'b0000;
      #1;
      chk("drop_ready", a_s_tready, 0);

      // Single requester 2, then 0 and 3 compete: rr_ptr is 3.
      s_tdata[47:32] = 16'hA55A;
      s_tvalid = 4'b0100;
      serve(2, 16'hA55A, 1, 20);
      s_tvalid = 4'b1001;
      serve(3, 16'h4444, 0, 0);
      s_tvalid = 4'b0000;

      // Reset restores lowest-index-first priority.
      arstn = 1'b0;
      s_tvalid = 4'b1010;
      @(negedge clk);
      #1;
      chk("rst2_ready", a_s_tready, 0);
      arstn = 1'b1;
      serve(1, 16'h2222, 0, 0);
      s_tvalid = 4'b0000;

      // Timeout instance.
      @(negedge clk);
      arstn = 1'b0;
      @(negedge clk);
      arstn = 1'b1;
      s_tvalid = 4'b0011;
      #1;
      chk("t_ready0", t_s_tready, 4'b0001);
      @(negedge clk);
      chk("t_send", t_m_tvalid, 1);
      chk("t_grant0", t_grant_id, 0);
      m_tready = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         m_tready = 1'b0;
         chk("t_no_tmo", t_timeout_err, 0);
         chk("t_busy", t_busy, 1);
      end
      @(negedge clk);
      chk("t_tmo_pulse", t_timeout_err, 1);
      chk("t_tmo_idle", t_busy, 0);
      chk("t_tmo_next", t_s_tready, 4'b0010);
      @(negedge clk);
      chk("t_tmo_once", t_timeout_err, 0);
      chk("t_grant1", t_grant_id, 1);
      chk("t_send1", t_m_tvalid, 1);

      // i2c_done lands in the same cycle the timer reaches 15.
      m_tready = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         m_tready = 1'b0;
         if (k == 15) i2c_done = 1'b1;
      end
      @(negedge clk);
      i2c_done = 1'b0;
      chk("t_edge_tmo", t_timeout_err, 0);
      chk("t_edge_idle", t_busy, 0);
      chk("t_edge_next", t_s_tready, 4'b0001);
      @(negedge clk);
      chk("t_edge_tmo2", t_timeout_err, 0);
      chk("t_grant0b", t_grant_id, 0);

      // Asynchronous reset while in WAIT_DONE.
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
      s_tvalid = 4'b0000;
      chk("t_wait_busy", t_busy, 1);
      chk("t_wait_valid", t_m_tvalid, 0);
      #2;
      arstn = 1'b0;
      s_tvalid = 4'b1111;
      #1;
      chk("t_arst_busy", t_busy, 0);
      chk("t_arst_ready", t_s_tready, 0);
      chk("t_arst_valid", t_m_tvalid, 0);
      chk("t_arst_data", t_m_tdata, 0);
      chk("t_arst_grant", t_grant_id, 0);
      chk("t_arst_tmo", t_timeout_err, 0);
      @(negedge clk);
      s_tvalid = 4'b0000;
      arstn = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
